if_fetch_stage: RTL

Instruction-fetch stage directly upstream of the decode stage. It holds the PC, fetches each 32-bit instruction as four byte reads over an 8-bit memory port, assembles them little-endian, and presents {pc, instruction} with a valid/stall handshake to the IF/ID boundary. It accepts a branch redirect from later stages, which aborts any fetch in progress.

---
 rtl/if_fetch_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: builds each 32-bit instruction from four byte
// reads over an 8-bit memory port (little-endian). It presents {pc, instruction}
// to decode with a valid/stall handshake. A branch redirect aborts any fetch
// that is in progress.
module if_fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_in,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  mem_request,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [7:0]            mem_data,
  input  logic                  mem_ready,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_instruction
);

  // The encoding keeps FETCHk == k, so the low two bits give the byte offset.
  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    FETCH3 = 3'd3,
    HOLD   = 3'd4
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [23:0]             buf_q;       // bytes 0..2; byte 3 goes straight to the output
  logic                    out_valid_q;
  logic [ADDR_WIDTH-1:0]   out_pc_q;
  logic [INST_WIDTH-1:0]   out_instr_q;

  logic                    accept;
  logic [ADDR_WIDTH-1:0]   pc_d;

  assign accept = out_valid_q & ~stall_in;

  // Memory request and address decode from the state and pc.
  // A reset that arrives mid-fetch drops the request in the same cycle.
  // NOTE: every output of always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    mem_request = 1'b0;
    mem_address = pc_q;
    if (state_q != HOLD) begin
      mem_request = ~reset;
      mem_address = pc_q + ADDR_WIDTH'(state_q[1:0]);
    end
  end

  // Next pc: a redirect (word-aligned) takes priority over the +4 on accept.
  always_comb begin
    pc_d = pc_q;
    if (branch_flag)
      pc_d = {branch_target[ADDR_WIDTH-1:2], 2'b00};
    else if (state_q == HOLD && accept)
      pc_d = pc_q + ADDR_WIDTH'(4);
  end

  // Fetch sequencer, byte assembly and registered IF/ID outputs.
  // NOTE: state uses non-blocking assignments so that every register samples
  // the pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH0;
      pc_q        <= RESET_PC;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= RESET_PC;
      out_instr_q <= '0;
    end else if (branch_flag) begin
      state_q     <= FETCH0;
      pc_q        <= pc_d;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      unique case (state_q)
        FETCH0: if (mem_ready) begin
          buf_q[7:0] <= mem_data;
          state_q    <= FETCH1;
        end
        FETCH1: if (mem_ready) begin
          buf_q[15:8] <= mem_data;
          state_q     <= FETCH2;
        end
        FETCH2: if (mem_ready) begin
          buf_q[23:16] <= mem_data;
          state_q      <= FETCH3;
        end
        FETCH3: if (mem_ready) begin
          out_instr_q <= {mem_data, buf_q};
          out_pc_q    <= pc_q;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: if (accept) begin
          out_valid_q <= 1'b0;
          state_q     <= FETCH0;
        end
        default: state_q <= FETCH0;
      endcase
    end
  end

  assign out_valid       = out_valid_q;
  assign out_pc          = out_pc_q;
  assign out_instruction = out_instr_q;

endmodule
